// File: rtl/mem_read_responder_pkg.sv
// Shared definitions for the memory read responder: bus widths, the default
// read latency and the record carried by each stage of the read pipeline.
package mem_resp_pkg;

    localparam int DATA_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int DEFAULT_LATENCY = 4;

    // One slot of the read-return pipeline; data is kept at zero in empty slots
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic              err;
    } stage_t;

endpackage

// File: rtl/mem_read_responder_if.sv
// Request/response bus of the memory read responder. The requester drives the
// master side, the responder sits on the slave side.
interface mem_read_responder_if;
    import mem_resp_pkg::*;

    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              err;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy, err
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy, err
    );

endinterface

// File: rtl/mem_read_responder_array.sv
// Word storage for the read responder: single port, write on the rising edge,
// read combinationally from the same index. Contents are not initialised.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

    // Store the write word at the end of the request cycle
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_read_responder.sv
// Memory read responder: accepts one read or write per cycle with no
// backpressure and returns each read's data exactly LATENCY cycles later
// through a shift pipeline of {valid, data, err} records.
// Optional feature: define MEM_RESP_ALIGN_CHK_EN to flag odd-address reads
// with err and to discard odd-address writes.
module mem_read_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_read_responder_if.slave  bus
);

    stage_t                r_pipe [LATENCY];
    stage_t                w_newStage;
    logic                  w_isRead;
    logic                  w_we;
    logic                  w_misaligned;
    logic                  w_busy;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_unusedAddr;

    assign w_idx        = bus.addr[DEPTH_LOG2:1];
    assign w_unusedAddr = ^bus.addr;

`ifdef MEM_RESP_ALIGN_CHK_EN
    assign w_misaligned = bus.addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Writes are ignored while reset is held and, with alignment checking, on odd addresses
    assign w_we     = rst_n & bus.enable & bus.wr & ~w_misaligned;
    assign w_isRead = bus.enable & ~bus.wr;

    mem_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (bus.data_in),
        .o_rdata (w_rdata)
    );

    // Build the record entering the pipeline; non-read cycles inject an all-zero slot
    always_comb begin
        w_newStage       = '0;
        w_newStage.valid = w_isRead;
        w_newStage.data  = w_isRead ? w_rdata : '0;
        w_newStage.err   = w_isRead & w_misaligned;
    end

    // Shift read results toward the output; reset drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_newStage;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Busy whenever any pipeline slot holds a read
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            w_busy = w_busy | r_pipe[i].valid;
        end
    end

    assign bus.data_valid = r_pipe[LATENCY-1].valid;
    assign bus.data_out   = r_pipe[LATENCY-1].data;
    assign bus.err        = r_pipe[LATENCY-1].err;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_mem_read_responder.sv
// Self-checking bench for mem_read_responder: directed vector table, hand-written
// multi-cycle sequences (burst reads, reset mid-flight, alignment handling,
// LATENCY=1 instance) and randomized traffic against a queue-based model.
module tb_mem_read_responder;
    import mem_resp_pkg::*;

    localparam int LAT = 4;
`ifdef MEM_RESP_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mem_read_responder_if bus ();
    mem_read_responder_if bus1 ();

    mem_read_responder #(.LATENCY(LAT), .DEPTH_LOG2(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_read_responder #(.LATENCY(1), .DEPTH_LOG2(11)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
        bit          err;
    } resp_t;

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        expValid;
        logic [15:0] expData;
        logic        expBusy;
    } vec_t;

    resp_t       respQ [$];
    logic [15:0] modelMem [2048];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mv, me, mb;
    logic [15:0] md;
    vec_t        vecs [19];

    function automatic int wordIdx(input logic [15:0] a);
        return int'(a[11:1]);
    endfunction

    function automatic vec_t mkVec(input logic en, input logic wr, input logic [15:0] a,
                                   input logic [15:0] d, input logic v, input logic [15:0] ed,
                                   input logic b);
        vec_t r;
        r.en = en; r.wr = wr; r.addr = a; r.din = d;
        r.expValid = v; r.expData = ed; r.expBusy = b;
        return r;
    endfunction

    // Drive one request for the current cycle and record its effect in the model
    task automatic applyStimulus(input logic en, input logic w, input logic [15:0] a,
                                 input logic [15:0] d);
        resp_t r;
        bus.enable  = en;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        if (en && rst_n) begin
            if (!w) begin
                r.due  = cyc + LAT;
                r.data = modelMem[wordIdx(a)];
                r.err  = ALIGN && a[0];
                respQ.push_back(r);
            end else if (!(ALIGN && a[0])) begin
                modelMem[wordIdx(a)] = d;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [15:0] d,
                            input logic e, input logic b);
        checkOutput({tag, ".data_valid"}, 32'(bus.data_valid), 32'(v));
        checkOutput({tag, ".data_out"},   32'(bus.data_out),   32'(d));
        checkOutput({tag, ".err"},        32'(bus.err),        32'(e));
        checkOutput({tag, ".busy"},       32'(bus.busy),       32'(b));
    endtask

    // What the model says the outputs of the current cycle should be
    task automatic modelExpect();
        mb = (respQ.size() != 0);
        mv = 1'b0; md = 16'h0000; me = 1'b0;
        if (respQ.size() != 0 && respQ[0].due == cyc) begin
            mv = 1'b1;
            md = respQ[0].data;
            me = respQ[0].err;
            void'(respQ.pop_front());
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        modelExpect();
    endtask

    initial begin
        logic [15:0] a;
        logic        en, w;
        int          idx;

        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus1.enable = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.data_in = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #1 checkAll("reset_async", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        checkAll("reset_held", 1'b0, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed table: single write/read latency and write-after-read isolation
        vecs[0]  = mkVec(1, 1, 16'h0010, 16'h1234, 0, 16'h0000, 0);
        vecs[1]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[2]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[3]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[4]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[5]  = mkVec(1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0);
        vecs[6]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
        vecs[7]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
        vecs[8]  = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
        vecs[9]  = mkVec(0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 1);
        vecs[10] = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[11] = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[12] = mkVec(1, 1, 16'h0020, 16'hBEEF, 0, 16'h0000, 0);
        vecs[13] = mkVec(1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 0);
        vecs[14] = mkVec(1, 1, 16'h0020, 16'h0000, 0, 16'h0000, 1);
        vecs[15] = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
        vecs[16] = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1);
        vecs[17] = mkVec(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1);
        vecs[18] = mkVec(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        for (int i = 0; i < 19; i++) begin
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData, 1'b0, vecs[i].expBusy);
            applyStimulus(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
        end

        // Preload 16 words at 0x0100.. with A000..A00F
        for (int k = 0; k < 16; k++) begin
            tick();
            applyStimulus(1'b1, 1'b1, 16'h0100 + 16'(2 * k), 16'hA000 + 16'(k));
        end

        // Eight back-to-back reads produce eight back-to-back responses in order
        for (int r = 0; r < 14; r++) begin
            tick();
            checkAll($sformatf("burst%0d", r), (r >= 4 && r <= 11),
                     (r >= 4 && r <= 11) ? 16'hA000 + 16'(r - 4) : 16'h0000,
                     1'b0, (r >= 1 && r <= 11));
            if (r < 8) applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(2 * r), 16'h0000);
            else       applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        end

        // Reset with three reads in flight, plus a write attempted during reset
        for (int r = 0; r < 4; r++) begin
            tick();
            checkAll($sformatf("prerst%0d", r), mv, md, me, mb);
            if (r < 3) applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
            else       applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'h0100, 16'hDEAD);
        respQ.delete();
        #2 checkAll("rst_immediate", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        checkAll("rst_edge", 1'b0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++) begin
            tick();
            checkAll($sformatf("postrst%0d", r), 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        for (int r = 0; r < 6; r++) begin
            tick();
            checkAll($sformatf("rstread%0d", r), (r == 4), (r == 4) ? 16'hA000 : 16'h0000,
                     1'b0, (r >= 1 && r <= 4));
            if (r == 0) applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000);
            else        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        end

        // Odd-address handling: err and write discard only with alignment checking
        for (int r = 0; r < 9; r++) begin
            tick();
            if (r == 5)      checkAll("align_rd11", 1'b1, 16'h1234, ALIGN, 1'b1);
            else if (r == 7) checkAll("align_rd12", 1'b1, ALIGN ? 16'h7777 : 16'h5555, 1'b0, 1'b1);
            else             checkAll($sformatf("align%0d", r), mv, md, me, mb);
            case (r)
                0:       applyStimulus(1'b1, 1'b1, 16'h0012, 16'h7777);
                1:       applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000);
                2:       applyStimulus(1'b1, 1'b1, 16'h0013, 16'h5555);
                3:       applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000);
                default: applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
            endcase
        end

        // Randomized traffic over the preloaded words, upper address bits scrambled
        for (int r = 0; r < 400; r++) begin
            tick();
            checkAll("rand", mv, md, me, mb);
            en  = ($urandom % 4) != 0;
            w   = ($urandom % 3) == 0;
            idx = 16'h80 + int'($urandom % 16);
            a   = {4'($urandom), 11'(idx), 1'($urandom)};
            applyStimulus(en, w, a, 16'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int r = 0; r < LAT + 2; r++) begin
            tick();
            checkAll("drain", mv, md, me, mb);
        end

        // LATENCY=1 instance: next-cycle response and continuous valid
        tick();
        bus1.enable = 1'b1; bus1.wr = 1'b1; bus1.addr = 16'h0004; bus1.data_in = 16'h0055;
        tick();
        bus1.addr = 16'h0006; bus1.data_in = 16'h0066;
        for (int r = 0; r < 8; r++) begin
            tick();
            checkOutput($sformatf("lat1_valid%0d", r), 32'(bus1.data_valid), 32'(r >= 1 && r <= 6));
            checkOutput($sformatf("lat1_data%0d", r), 32'(bus1.data_out),
                        (r >= 1 && r <= 6) ? (((r - 1) % 2 == 0) ? 32'h0055 : 32'h0066) : 32'h0);
            checkOutput($sformatf("lat1_busy%0d", r), 32'(bus1.busy), 32'(r >= 1 && r <= 6));
            bus1.enable = (r < 6);
            bus1.wr     = 1'b0;
            bus1.addr   = (r % 2 == 0) ? 16'h0004 : 16'h0006;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_read_responder.md
MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from accepted read to data_valid; legal range 1..8.
REQ-002 Parameter DEPTH_LOG2, default 11, log2 of storage words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  request strobe, one request per cycle when high.
REQ-006 wr  input  1  qualifies enable: 1 = write, 0 = read.
REQ-007 addr  input  16  byte address; word index = addr[DEPTH_LOG2:1], addr[0] ignored except per REQ-024.
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data, meaningful only while data_valid is high.
REQ-010 data_valid  output  1  high for exactly one cycle per accepted read.
REQ-011 busy  output  1  high while any read is in flight.
REQ-012 err  output  1  alignment error flag, qualified by data_valid.

Function
REQ-013 SHALL accept a request on every cycle with enable=1; there is no backpressure.
REQ-014 Write (enable=1, wr=1) SHALL update the word at the rising edge ending that cycle and produce no response.
REQ-015 Read (enable=1, wr=0) in cycle N SHALL sample the array in cycle N and assert data_valid with that data in cycle N+LATENCY.
REQ-016 Pipeline SHALL be a LATENCY-deep shift of {valid, data, err}; back-to-back reads yield back-to-back data_valid cycles, in issue order.
REQ-017 A read in cycle N+1 of an address written in cycle N SHALL return the new data.
REQ-018 A write to an address with a read in flight SHALL NOT alter that in-flight read's data.
REQ-019 busy SHALL equal the OR of all pipeline valid bits; an in-flight counter, if used, saturates at LATENCY and never wraps.
REQ-020 data_out SHALL hold 16'h0000 whenever data_valid is low.
REQ-021 Array contents SHALL be undefined at power-up; no initialization logic.

Reset
REQ-022 rst_n low SHALL immediately clear all pipeline valid bits, and force data_valid=0, busy=0, err=0, data_out=16'h0000.
REQ-023 Reset mid-operation SHALL drop all in-flight reads without any late data_valid and SHALL retain array contents; requests while rst_n is low are ignored.

Configuration
REQ-024 With MEM_RESP_ALIGN_CHK_EN defined, a read with addr[0]=1 SHALL still return data after LATENCY with err=1 on the data_valid cycle, and a write with addr[0]=1 SHALL be discarded; without the macro, err is tied 0 and addr[0] is ignored for all requests.

Structure
REQ-025 Shared package mem_resp_pkg SHALL hold DATA_W=16, ADDR_W=16, the default LATENCY, and the pipeline stage struct typedef {valid, data, err}.
REQ-026 Storage SHALL be a sub-module mem_resp_array (single-port, synchronous write, combinational read); pipeline and control stay in the top module.

Verification
REQ-027 Write 16'h1234 to 16'h0010, then read 16'h0010 in cycle 5 -> data_valid only in cycle 9, data_out=16'h1234.
REQ-028 Preload 8 words at 16'h0100..16'h010E with 16'hA000..16'hA007; 8 back-to-back reads in cycles 10..17 -> data_valid in cycles 14..21 returning A000..A007 in order; busy high in cycles 11..21.
REQ-029 Write 16'hBEEF to 16'h0020 in cycle 3, read it in cycle 4 -> data_out=16'hBEEF in cycle 8; write 16'h0000 to 16'h0020 in cycle 5 does not change that response.
REQ-030 Issue 3 reads, assert rst_n low 2 cycles later for 1 cycle -> no data_valid afterward, busy=0 immediately; a subsequent read returns pre-reset array contents.
REQ-031 With MEM_RESP_ALIGN_CHK_EN: read 16'h0011 -> data_valid with err=1 after LATENCY; write 16'h5555 to 16'h0013 then read 16'h0012 -> old data, err=0. Without the macro: err always 0.
REQ-032 LATENCY=1: read in cycle N -> data_valid in cycle N+1; continuous reads -> data_valid continuously high.
